video_sync_decoder: RTL

- Parametrised successor to the composite sync separator. Sits between the video ADC front end and the line/frame capture logic.
- Slices sync from raw ADC samples using a runtime threshold with hysteresis, and classifies pulses as H-sync, V-sync or equalising/noise.
- Tracks x/y position and odd/even field, gates active video by horizontal and vertical windows, and flags loss of sync with a line watchdog.

---
 rtl/video_sync_decoder.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/video_sync_decoder.sv
// Composite sync separator: slices sync from raw ADC samples with hysteresis, classifies
// pulse widths, and tracks x/y position, field parity, the active window and loss of lock.
module video_sync_decoder #(
  parameter int ADC_WIDTH        = 12,
  parameter int HYST             = 64,
  parameter int HSYNC_MIN_WIDTH  = 120,
  parameter int VSYNC_MIN_WIDTH  = 800,
  parameter int HALF_LINE        = 1180,
  parameter int BACK_PORCH_DELAY = 175,
  parameter int ACTIVE_WIDTH     = 1920,
  parameter int V_ACTIVE_START   = 21,
  parameter int V_ACTIVE_LINES   = 240,
  parameter int X_WIDTH          = 12,
  parameter int Y_WIDTH          = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_valid,
  input  logic [ADC_WIDTH-1:0] adc_data,
  input  logic [ADC_WIDTH-1:0] sync_thresh,
  output logic                 h_sync_pulse,
  output logic                 v_sync_pulse,
  output logic                 field,
  output logic                 active_video,
  output logic [X_WIDTH-1:0]   x_coord,
  output logic [Y_WIDTH-1:0]   y_coord,
  output logic                 sync_lost
);

  localparam int ADC_EXT = ADC_WIDTH + 1;
  localparam logic [ADC_EXT-1:0] HYST_EXT  = ADC_EXT'(HYST);
  localparam logic [X_WIDTH-1:0] X_ONE     = X_WIDTH'(1);
  localparam logic [X_WIDTH-1:0] X_MAX     = {X_WIDTH{1'b1}};
  localparam logic [X_WIDTH-1:0] X_PRE_MAX = X_WIDTH'((1 << X_WIDTH) - 2);
  localparam logic [Y_WIDTH-1:0] Y_ONE     = Y_WIDTH'(1);
  localparam logic [Y_WIDTH-1:0] Y_MAX     = {Y_WIDTH{1'b1}};
  localparam logic [X_WIDTH-1:0] HS_MIN    = X_WIDTH'(HSYNC_MIN_WIDTH);
  localparam logic [X_WIDTH-1:0] VS_MIN    = X_WIDTH'(VSYNC_MIN_WIDTH);
  localparam logic [X_WIDTH-1:0] HALF_X    = X_WIDTH'(HALF_LINE);
  localparam logic [X_WIDTH-1:0] ACT_X_LO  = X_WIDTH'(BACK_PORCH_DELAY);
  localparam logic [X_WIDTH-1:0] ACT_X_HI  = X_WIDTH'(BACK_PORCH_DELAY + ACTIVE_WIDTH);
  localparam logic [Y_WIDTH-1:0] ACT_Y_LO  = Y_WIDTH'(V_ACTIVE_START);
  localparam logic [Y_WIDTH-1:0] ACT_Y_HI  = Y_WIDTH'(V_ACTIVE_START + V_ACTIVE_LINES);

  typedef enum logic {LVL_VIDEO = 1'b0, LVL_SYNC = 1'b1} level_e;

  level_e               level_q, level_d;
  logic [X_WIDTH-1:0]   low_cnt_q, low_cnt_d;
  logic [X_WIDTH-1:0]   x_q, x_d;
  logic [Y_WIDTH-1:0]   y_q, y_d;
  logic                 field_q, field_d;
  logic                 field_next_q, field_next_d;
  logic                 v_pend_q, v_pend_d;
  logic                 sync_lost_q, sync_lost_d;
  logic                 h_pulse_q, h_pulse_d;
  logic                 v_pulse_q, v_pulse_d;
  logic                 active_q, active_d;

  logic [ADC_EXT-1:0]   leave_thresh;
  logic                 enter_sync, leave_sync, sync_end;
  logic                 is_vsync, is_hsync, in_x, in_y;
  logic [X_WIDTH-1:0]   x_sat;
  logic [Y_WIDTH-1:0]   y_sat;

  // Slicer: leave threshold kept one bit wider so a large threshold never wraps low.
  always_comb begin
    leave_thresh = {1'b0, sync_thresh} + HYST_EXT;
    enter_sync   = adc_data < sync_thresh;
    leave_sync   = {1'b0, adc_data} >= leave_thresh;
    level_d      = level_q;
    sync_end     = 1'b0;
    if (sample_valid) begin
      case (level_q)
        LVL_VIDEO: if (enter_sync) level_d = LVL_SYNC;
        LVL_SYNC: begin
          if (leave_sync) begin
            level_d  = LVL_VIDEO;
            sync_end = 1'b1;
          end
        end
        default: level_d = LVL_VIDEO;
      endcase
    end
  end

  always_comb begin
    low_cnt_d    = low_cnt_q;
    x_d          = x_q;
    y_d          = y_q;
    field_d      = field_q;
    field_next_d = field_next_q;
    v_pend_d     = v_pend_q;
    sync_lost_d  = sync_lost_q;
    active_d     = active_q;
    h_pulse_d    = 1'b0;
    v_pulse_d    = 1'b0;

    x_sat    = (x_q == X_MAX) ? X_MAX : x_q + X_ONE;
    y_sat    = (y_q == Y_MAX) ? Y_MAX : y_q + Y_ONE;
    is_vsync = sync_end && (low_cnt_q > VS_MIN);
    is_hsync = sync_end && !is_vsync && (low_cnt_q > HS_MIN);
    in_x     = (x_q > ACT_X_LO) && (x_q <= ACT_X_HI);
    in_y     = (y_q >= ACT_Y_LO) && (y_q < ACT_Y_HI);

    if (sample_valid) begin
      active_d = in_x && in_y && (level_q == LVL_VIDEO) && !sync_lost_q;

      if (sync_end)
        low_cnt_d = '0;
      else if (level_d == LVL_SYNC && low_cnt_q != X_MAX)
        low_cnt_d = low_cnt_q + X_ONE;

      x_d = x_sat;
      // Line watchdog: a full counter span without H-sync drops lock and any pending V-sync.
      if (x_q == X_PRE_MAX) begin
        sync_lost_d = 1'b1;
        v_pend_d    = 1'b0;
      end

      if (is_vsync) begin
        v_pend_d     = 1'b1;
        field_next_d = (x_q >= HALF_X);
      end

      if (is_hsync) begin
        h_pulse_d   = 1'b1;
        x_d         = '0;
        sync_lost_d = 1'b0;
        if (v_pend_q) begin
          v_pulse_d = 1'b1;
          y_d       = '0;
          field_d   = field_next_q;
          v_pend_d  = 1'b0;
        end else begin
          y_d = y_sat;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q      <= LVL_VIDEO;
      low_cnt_q    <= '0;
      x_q          <= '0;
      y_q          <= '0;
      field_q      <= 1'b0;
      field_next_q <= 1'b0;
      v_pend_q     <= 1'b0;
      sync_lost_q  <= 1'b1;
      h_pulse_q    <= 1'b0;
      v_pulse_q    <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      level_q      <= level_d;
      low_cnt_q    <= low_cnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      field_q      <= field_d;
      field_next_q <= field_next_d;
      v_pend_q     <= v_pend_d;
      sync_lost_q  <= sync_lost_d;
      h_pulse_q    <= h_pulse_d;
      v_pulse_q    <= v_pulse_d;
      active_q     <= active_d;
    end
  end

  assign h_sync_pulse = h_pulse_q;
  assign v_sync_pulse = v_pulse_q;
  assign field        = field_q;
  assign active_video = active_q;
  assign x_coord      = x_q;
  assign y_coord      = y_q;
  assign sync_lost    = sync_lost_q;

endmodule
